circ_vector_buffer: RTL and testbench

Parametrised circulating vector store for the iterative solver datapath: holds DEPTH signed DATA_W-bit elements. The vector is filled once through a valid/ready load port, then rotated one element per shift, presenting the current head element and its logical index. A write-back path replaces the head element as it circulates, so updated solution values can be kept in place. It supersedes the fixed 16x16 rotating register with generic width/depth, an explicit fill/run mode, index tracking, lap counting and in-place update.

---
 rtl/circ_vector_buffer_pkg.sv | 30 +++
 rtl/circ_vector_buffer_if.sv | 43 ++++
 rtl/circ_vector_buffer_mod_counter.sv | 45 ++++
 rtl/circ_vector_buffer.sv | 133 +++++++++++++
 tb/tb_circ_vector_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/circ_vector_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : circ_vector_buffer_pkg
// Purpose  : Shared types and helpers for the solver circulating buffers.
//            Provides the FILL/RUN mode enum and an index-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package circ_vector_buffer_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } buf_state_t;

  // Bits needed to hold an index in 0..n-1 (n >= 2).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/circ_vector_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : circ_vector_buffer_if
// Purpose  : Load / rotate / write-back bus of the circulating vector buffer.
//            master : solver side (drives clear, load, shift, update)
//            slave  : buffer side (drives ready, head data, index, status)
// Ports    : none (signals grouped as interface members)
// Revision : 1.0 - initial release
// ============================================================================
interface circ_vector_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int LAP_W  = 8
);
  import circ_vector_buffer_pkg::*;

  localparam int IDX_W = clog2(DEPTH);

  logic                     clear;
  logic                     load_valid;
  logic signed [DATA_W-1:0] load_data;
  logic                     load_ready;
  logic                     shift_en;
  logic                     upd_en;
  logic signed [DATA_W-1:0] upd_data;
  logic signed [DATA_W-1:0] data_o;
  logic [IDX_W-1:0]         idx_o;
  logic                     wrap_o;
  logic [LAP_W-1:0]         lap_o;
  logic                     full_o;

  modport master (
    output clear, load_valid, load_data, shift_en, upd_en, upd_data,
    input  load_ready, data_o, idx_o, wrap_o, lap_o, full_o
  );

  modport slave (
    input  clear, load_valid, load_data, shift_en, upd_en, upd_data,
    output load_ready, data_o, idx_o, wrap_o, lap_o, full_o
  );

endinterface
`default_nettype wire

// File: rtl/circ_vector_buffer_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Modulo-N up counter with synchronous clear and a combinational
//            wrap flag that is high on the edge where the count returns to 0.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clr         - synchronous clear to 0 (below rst in priority)
//            i_en          - advance by one
//            o_count       - current count, 0..MODULUS-1
//            o_wrap        - advancing from MODULUS-1 to 0 this cycle
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MODULUS = 16,
  parameter int WIDTH   = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_wrap
);

  localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == c_last);
  assign o_wrap    = i_en && w_at_last && !i_clr;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/circ_vector_buffer.sv
`default_nettype none
// ============================================================================
// Module   : circ_vector_buffer
// Purpose  : Circulating store of DEPTH signed elements. Filled once through
//            a valid/ready port, then rotated one element per shift with the
//            head element, its logical index, a wrap pulse and a lap count
//            presented. The head can be overwritten in place as it passes.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - circ_vector_buffer_if.slave (clear, load, shift, update,
//                   head data/index, wrap, lap, full, load_ready)
// Revision : 1.0 - initial release
// ============================================================================
module circ_vector_buffer
  import circ_vector_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int LAP_W  = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  circ_vector_buffer_if.slave  bus
);

  localparam int IDX_W = clog2(DEPTH);

  buf_state_t               r_state;
  buf_state_t               w_state_next;
  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic                     r_loaded;
  logic                     r_wrap;
  logic [LAP_W-1:0]         r_lap;

  logic                     w_load_acc;
  logic                     w_shift;
  logic                     w_upd;
  logic [IDX_W-1:0]         w_load_cnt;
  logic                     w_load_last;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_idx_wrap;

  // Clear outranks every mode operation, so it masks all qualified strobes.
  assign w_load_acc = bus.load_valid && (r_state == ST_FILL) && !bus.clear;
  assign w_shift    = bus.shift_en   && (r_state == ST_RUN)  && !bus.clear;
  assign w_upd      = bus.upd_en     && (r_state == ST_RUN)  && !bus.clear;

  // Load position; its wrap marks the final element of the fill.
  mod_counter #(
    .MODULUS (DEPTH),
    .WIDTH   (IDX_W)
  ) u_load_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.clear),
    .i_en    (w_load_acc),
    .o_count (w_load_cnt),
    .o_wrap  (w_load_last)
  );

  // Head index; stays 0 throughout FILL because shifts are masked there.
  mod_counter #(
    .MODULUS (DEPTH),
    .WIDTH   (IDX_W)
  ) u_idx_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.clear),
    .i_en    (w_shift),
    .o_count (w_idx),
    .o_wrap  (w_idx_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = ST_FILL;
    end else if ((r_state == ST_FILL) && w_load_last) begin
      w_state_next = ST_RUN;
    end
  end

  // Load and write-back are mutually exclusive by mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_load_acc) begin
        r_mem[w_load_cnt] <= bus.load_data;
      end
      if (w_upd) begin
        r_mem[w_idx] <= bus.upd_data;
      end
    end
  end

  // After clear the stale contents stay in storage; this flag hides them
  // until the first element of the new fill arrives.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_loaded <= 1'b0;
      r_wrap   <= 1'b0;
      r_lap    <= '0;
    end else begin
      if (w_load_acc) begin
        r_loaded <= 1'b1;
      end
      r_wrap <= w_idx_wrap;
      if (w_idx_wrap) begin
        r_lap <= r_lap + 1'b1;
      end
    end
  end

  assign bus.load_ready = (r_state == ST_FILL);
  assign bus.full_o     = (r_state == ST_RUN);
  assign bus.data_o     = r_loaded ? r_mem[w_idx] : '0;
  assign bus.idx_o      = w_idx;
  assign bus.wrap_o     = r_wrap;
  assign bus.lap_o      = r_lap;

endmodule
`default_nettype wire

// File: tb/tb_circ_vector_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_circ_vector_buffer
// Purpose  : Self-checking bench for circ_vector_buffer: a DEPTH=16 instance
//            and a DEPTH=4 instance, with expected head values queued as
//            stimulus is driven and compared as the DUT presents them.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_circ_vector_buffer;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  logic signed [63:0] exp_q [$];

  circ_vector_buffer_if #(.DATA_W(16), .DEPTH(16), .LAP_W(8)) bus_a ();
  circ_vector_buffer_if #(.DATA_W(16), .DEPTH(4),  .LAP_W(8)) bus_b ();

  circ_vector_buffer #(.DATA_W(16), .DEPTH(16), .LAP_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  circ_vector_buffer #(.DATA_W(16), .DEPTH(4), .LAP_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic signed [63:0] obs);
    logic signed [63:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  logic signed [15:0] mb [4];
  int bidx;
  int wraps;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_a.clear = 0; bus_a.load_valid = 0; bus_a.load_data = 0;
    bus_a.shift_en = 0; bus_a.upd_en = 0; bus_a.upd_data = 0;
    bus_b.clear = 0; bus_b.load_valid = 0; bus_b.load_data = 0;
    bus_b.shift_en = 0; bus_b.upd_en = 0; bus_b.upd_data = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ---------------- reset state ----------------
    check("rst_ready", bus_a.load_ready, 1);
    check("rst_full",  bus_a.full_o, 0);
    check("rst_idx",   bus_a.idx_o, 0);
    check("rst_lap",   bus_a.lap_o, 0);
    check("rst_wrap",  bus_a.wrap_o, 0);
    check("rst_data",  bus_a.data_o, 0);

    // ---------------- DEPTH=4 signed / update ----------------
    mb[0] = -16'sd3; mb[1] = 16'sd7; mb[2] = -16'sd32768; mb[3] = 16'sd32767;
    for (int k = 0; k < 4; k++) begin
      bus_b.load_valid = 1;
      bus_b.load_data  = mb[k];
      tick();
    end
    bus_b.load_valid = 0;
    check("b_full", bus_b.full_o, 1);
    check("b_ready", bus_b.load_ready, 0);
    exp_q.push_back(-3);
    check_head("b_head0", bus_b.data_o);

    bus_b.shift_en = 1;
    exp_q.push_back(mb[1]);
    tick();
    bus_b.shift_en = 0;
    check_head("b_shift1", bus_b.data_o);
    check("b_idx1", bus_b.idx_o, 1);

    mb[1] = 16'sd100;
    bus_b.shift_en = 1; bus_b.upd_en = 1; bus_b.upd_data = 16'sd100;
    exp_q.push_back(mb[2]);
    tick();
    bus_b.shift_en = 0; bus_b.upd_en = 0;
    check_head("b_shupd", bus_b.data_o);
    check("b_idx2", bus_b.idx_o, 2);

    mb[2] = -16'sd5;
    bus_b.upd_en = 1; bus_b.upd_data = -16'sd5;
    exp_q.push_back(-5);
    tick();
    bus_b.upd_en = 0;
    check_head("b_upd", bus_b.data_o);
    check("b_upd_idx", bus_b.idx_o, 2);
    check("b_upd_wrap", bus_b.wrap_o, 0);

    bidx = 2;
    for (int i = 0; i < 4; i++) begin
      bidx = (bidx + 1) % 4;
      bus_b.shift_en = 1;
      exp_q.push_back(mb[bidx]);
      tick();
      check_head("b_rot", bus_b.data_o);
      check("b_rot_idx", bus_b.idx_o, bidx);
      check("b_rot_wrap", bus_b.wrap_o, (bidx == 0) ? 1 : 0);
    end
    bus_b.shift_en = 0;
    check("b_lap", bus_b.lap_o, 1);

    // ---------------- DEPTH=16: FILL ignores shift/update ----------------
    bus_a.shift_en = 1; bus_a.upd_en = 1; bus_a.upd_data = 16'sd55;
    tick();
    bus_a.shift_en = 0; bus_a.upd_en = 0;
    check("fill_ign_idx", bus_a.idx_o, 0);
    check("fill_ign_data", bus_a.data_o, 0);
    check("fill_ign_ready", bus_a.load_ready, 1);

    for (int k = 1; k <= 16; k++) begin
      bus_a.load_valid = 1;
      bus_a.load_data  = 16'(k);
      tick();
      if (k == 1)  check("fill_first_data", bus_a.data_o, 1);
      if (k == 15) check("fill_ready15", bus_a.load_ready, 1);
    end
    bus_a.load_valid = 0;
    check("fill_ready_drop", bus_a.load_ready, 0);
    check("fill_full", bus_a.full_o, 1);
    check("fill_idx", bus_a.idx_o, 0);
    check("fill_data", bus_a.data_o, 1);

    // Load in RUN must be ignored.
    bus_a.load_valid = 1; bus_a.load_data = 16'sd9;
    tick();
    bus_a.load_valid = 0;
    check("run_ld_ign_data", bus_a.data_o, 1);
    check("run_ld_ign_ready", bus_a.load_ready, 0);

    wraps = 0;
    for (int i = 1; i <= 16; i++) begin
      bus_a.shift_en = 1;
      exp_q.push_back((i < 16) ? i + 1 : 1);
      tick();
      check_head("a_rot", bus_a.data_o);
      check("a_rot_wrap", bus_a.wrap_o, (i == 16) ? 1 : 0);
      if (bus_a.wrap_o === 1'b1) wraps++;
    end
    bus_a.shift_en = 0;
    check("a_wrap_count", wraps, 1);
    check("a_lap1", bus_a.lap_o, 1);
    tick();
    check("a_wrap_one_cycle", bus_a.wrap_o, 0);

    // Advance to idx 5, lap 3.
    bus_a.shift_en = 1;
    for (int i = 0; i < 37; i++) tick();
    bus_a.shift_en = 0;
    check("a_mid_idx", bus_a.idx_o, 5);
    check("a_mid_lap", bus_a.lap_o, 3);
    check("a_mid_data", bus_a.data_o, 6);

    // ---------------- clear with simultaneous load ----------------
    bus_a.clear = 1; bus_a.load_valid = 1; bus_a.load_data = 16'sd77;
    tick();
    bus_a.clear = 0; bus_a.load_valid = 0;
    check("clr_ready", bus_a.load_ready, 1);
    check("clr_full", bus_a.full_o, 0);
    check("clr_idx", bus_a.idx_o, 0);
    check("clr_lap", bus_a.lap_o, 0);
    check("clr_wrap", bus_a.wrap_o, 0);
    check("clr_data", bus_a.data_o, 0);

    // Refill: if the cleared-cycle load had been taken, slot 0 would be 77.
    for (int k = 0; k < 16; k++) begin
      bus_a.load_valid = 1;
      bus_a.load_data  = 16'(101 + k);
      tick();
    end
    bus_a.load_valid = 0;
    check("refill_full", bus_a.full_o, 1);
    check("refill_data", bus_a.data_o, 101);

    bus_a.shift_en = 1;
    for (int i = 0; i < 3; i++) tick();
    bus_a.shift_en = 0;
    check("refill_shift_data", bus_a.data_o, 104);

    // ---------------- reset mid-rotation with pending load ----------------
    rst = 1; bus_a.load_valid = 1; bus_a.load_data = 16'sd5;
    tick();
    rst = 0; bus_a.load_valid = 0;
    check("rrst_ready", bus_a.load_ready, 1);
    check("rrst_full", bus_a.full_o, 0);
    check("rrst_idx", bus_a.idx_o, 0);
    check("rrst_lap", bus_a.lap_o, 0);
    check("rrst_wrap", bus_a.wrap_o, 0);
    check("rrst_data", bus_a.data_o, 0);
    check("rrst_b_full", bus_b.full_o, 0);

    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
